// File: rtl/scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : scan_mux
//  Purpose  : Registered N-channel selector with a manual mode and a scan mode.
//             Manual mode picks one WIDTH-bit channel by index. Scan mode walks
//             through the enabled channels on its own and dwells SCAN_DIV
//             cycles on each one, for example to drive a multiplexed
//             seven-segment display.
//  Ports    : clk       - rising-edge clock
//             rst_n     - asynchronous active-low reset
//             data_in   - packed channels, channel k = [k*WIDTH +: WIDTH]
//             mode      - 0 = manual, 1 = scan
//             sel       - channel index used in manual mode
//             en_mask   - per-channel enable used in scan mode
//             hold      - scan mode: freeze the dwell counter and the index
//             y         - registered selected data
//             ch_idx    - registered current channel index
//             ch_onehot - registered one-hot of ch_idx, zero when not valid
//             valid     - registered, high when y carries a legal channel
//  Revision : 1.0 - initial release
// ============================================================================
module scan_mux #(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 8,
    parameter  int SCAN_DIV = 16,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic [CHANNELS*WIDTH-1:0] data_in,
    input  wire logic                      mode,
    input  wire logic [SEL_W-1:0]          sel,
    input  wire logic [CHANNELS-1:0]       en_mask,
    input  wire logic                      hold,
    output logic      [WIDTH-1:0]          y,
    output logic      [SEL_W-1:0]          ch_idx,
    output logic      [CHANNELS-1:0]       ch_onehot,
    output logic                           valid
);

    // A one-cycle dwell still needs a one-bit counter to keep the logic uniform.
    localparam int                 c_CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [SEL_W:0]     c_CH_LIM   = (SEL_W + 1)'(CHANNELS);
    // The wrap arithmetic carries two extra bits: cur + offset < 3*CHANNELS.
    localparam logic [SEL_W+1:0]   c_MOD      = (SEL_W + 2)'(CHANNELS);

    logic [WIDTH-1:0]    r_y;
    logic [SEL_W-1:0]    r_ch_idx;
    logic [CHANNELS-1:0] r_onehot;
    logic                r_valid;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_cur_en;
    logic [SEL_W-1:0]    w_next;
    logic [SEL_W+1:0]    w_sum;
    logic [SEL_W-1:0]    w_idx_d;
    logic [c_CNT_W-1:0]  w_cnt_d;
    logic [SEL_W-1:0]    w_out_idx;
    logic                w_out_ok;
    logic [WIDTH-1:0]    w_y_d;
    logic [CHANNELS-1:0] w_onehot_d;

    // Current channel enable. An index at or beyond CHANNELS (possible after
    // manual mode) matches no channel and therefore reads as disabled.
    always_comb begin
        w_cur_en = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (r_ch_idx == SEL_W'(k)) begin
                w_cur_en = en_mask[k];
            end
        end
    end

    // Next enabled channel in circular order cur+1 .. cur+CHANNELS. Offsets
    // are walked from the farthest to the nearest so the nearest hit wins.
    // Offset CHANNELS lands back on cur, which covers the single-channel case.
    always_comb begin
        w_next = r_ch_idx;
        w_sum  = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            w_sum = {2'b00, r_ch_idx} + (SEL_W + 2)'(i);
            if (w_sum >= c_MOD) begin
                w_sum = w_sum - c_MOD;
            end
            if (w_sum >= c_MOD) begin
                w_sum = w_sum - c_MOD;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if ((w_sum == (SEL_W + 2)'(k)) && en_mask[k]) begin
                    w_next = SEL_W'(k);
                end
            end
        end
    end

    // Next-state selection for the index and dwell counter, plus the index
    // the registered outputs will present.
    always_comb begin
        w_idx_d   = r_ch_idx;
        w_cnt_d   = r_cnt;
        w_out_idx = r_ch_idx;
        w_out_ok  = 1'b0;
        if (!mode) begin
            w_idx_d   = sel;
            w_cnt_d   = '0;
            w_out_idx = sel;
            w_out_ok  = ({1'b0, sel} < c_CH_LIM);
        end else if (en_mask == '0) begin
            // Nothing to show: index and counter hold, outputs go invalid.
            w_out_ok = 1'b0;
        end else if (hold) begin
            // Frozen, but data keeps tracking the current channel if it is live.
            w_out_ok = w_cur_en;
        end else if (!w_cur_en || (r_cnt == c_CNT_LAST)) begin
            w_idx_d   = w_next;
            w_cnt_d   = '0;
            w_out_idx = w_next;
            w_out_ok  = 1'b1;
        end else begin
            w_cnt_d  = r_cnt + c_CNT_W'(1);
            w_out_ok = 1'b1;
        end
    end

    // Data and one-hot for the presented index.
    always_comb begin
        w_y_d      = '0;
        w_onehot_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_out_ok && (w_out_idx == SEL_W'(k))) begin
                w_y_d         = data_in[k*WIDTH +: WIDTH];
                w_onehot_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y      <= '0;
            r_ch_idx <= '0;
            r_onehot <= '0;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_y      <= w_y_d;
            r_ch_idx <= w_idx_d;
            r_onehot <= w_onehot_d;
            r_valid  <= w_out_ok;
            r_cnt    <= w_cnt_d;
        end
    end

    assign y         = r_y;
    assign ch_idx    = r_ch_idx;
    assign ch_onehot = r_onehot;
    assign valid     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_mux
//  Purpose  : Directed self-checking bench for scan_mux. One 8-channel
//             instance (SCAN_DIV=4) covers manual select, masked scanning,
//             hold, disabled-channel jumps, empty mask and reset; a 6-channel
//             instance covers out-of-range indices.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scan_mux;

    logic        clk;
    logic        rst_n;

    // 8-channel instance
    logic [31:0] data8;
    logic        mode8;
    logic [2:0]  sel8;
    logic [7:0]  mask8;
    logic        hold8;
    logic [3:0]  y8;
    logic [2:0]  idx8;
    logic [7:0]  oh8;
    logic        valid8;

    // 6-channel instance
    logic [23:0] data6;
    logic        mode6;
    logic [2:0]  sel6;
    logic [5:0]  mask6;
    logic        hold6;
    logic [3:0]  y6;
    logic [2:0]  idx6;
    logic [5:0]  oh6;
    logic        valid6;

    int n_total;
    int n_pass;
    int n_fail;
    int seq_tbl[5];

    scan_mux #(.WIDTH(4), .CHANNELS(8), .SCAN_DIV(4)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data8),
        .mode      (mode8),
        .sel       (sel8),
        .en_mask   (mask8),
        .hold      (hold8),
        .y         (y8),
        .ch_idx    (idx8),
        .ch_onehot (oh8),
        .valid     (valid8)
    );

    scan_mux #(.WIDTH(4), .CHANNELS(6), .SCAN_DIV(4)) u_dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data6),
        .mode      (mode6),
        .sel       (sel6),
        .en_mask   (mask6),
        .hold      (hold6),
        .y         (y6),
        .ch_idx    (idx6),
        .ch_onehot (oh6),
        .valid     (valid6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish within budget");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input int e_idx, input int e_y,
                          input int e_oh, input int e_valid);
        check({tag, "_idx"},   32'(idx8),   32'(e_idx));
        check({tag, "_y"},     32'(y8),     32'(e_y));
        check({tag, "_oh"},    32'(oh8),    32'(e_oh));
        check({tag, "_valid"}, 32'(valid8), 32'(e_valid));
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        seq_tbl = '{0, 2, 5, 7, 0};

        rst_n = 1'b0;
        data8 = 32'h8765_4321;
        mode8 = 1'b0;
        sel8  = 3'd5;
        mask8 = 8'h00;
        hold8 = 1'b0;
        data6 = 24'h65_4321;
        mode6 = 1'b0;
        sel6  = 3'd5;
        mask6 = 6'h00;
        hold6 = 1'b0;

        // Reset values
        #1;
        check8("reset", 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Manual select
        tick();
        check8("man_sel5", 5, 6, 8'h20, 1);
        check("m6_sel5_y",     32'(y6),     32'd6);
        check("m6_sel5_oh",    32'(oh6),    32'h20);
        check("m6_sel5_valid", 32'(valid6), 32'd1);
        sel8 = 3'd7;
        sel6 = 3'd6;
        tick();
        check8("man_sel7", 7, 8, 8'h80, 1);
        check("m6_oor_idx",   32'(idx6),   32'd6);
        check("m6_oor_y",     32'(y6),     32'd0);
        check("m6_oor_oh",    32'(oh6),    32'd0);
        check("m6_oor_valid", 32'(valid6), 32'd0);

        // Manual->scan from an out-of-range index jumps to the next enabled one
        mode6 = 1'b1;
        mask6 = 6'b00_0011;
        sel8  = 3'd0;
        tick();
        check("s6_jump_idx",   32'(idx6),   32'd1);
        check("s6_jump_y",     32'(y6),     32'd2);
        check("s6_jump_oh",    32'(oh6),    32'h02);
        check("s6_jump_valid", 32'(valid6), 32'd1);
        check8("man_sel0", 0, 1, 8'h01, 1);

        // Scan with mask 1010_0101: 0,2,5,7,0 each held 4 cycles
        mode8 = 1'b1;
        mask8 = 8'hA5;
        for (int n = 1; n < 20; n++) begin
            int e;
            tick();
            e = seq_tbl[n / 4];
            check("scan_idx", 32'(idx8), 32'(e));
            check("scan_y",   32'(y8),   32'(e + 1));
            check("scan_oh",  32'(oh8),  32'(1 << e));
        end

        // Hold at terminal count: index frozen, data still tracked
        hold8 = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("hold_idx", 32'(idx8), 32'd0);
            check("hold_y",   32'(y8),   32'd1);
        end
        data8[3:0] = 4'hC;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("hold_idx2", 32'(idx8), 32'd0);
            check("hold_ydat", 32'(y8),   32'hC);
        end
        data8[3:0] = 4'h1;
        hold8 = 1'b0;
        tick();
        check8("release", 2, 3, 8'h04, 1);
        tick();
        check("dwell2_idx", 32'(idx8), 32'd2);

        // Disable current channel: jump then full dwell
        mask8 = 8'hA1;
        tick();
        check8("dis_jump", 5, 6, 8'h20, 1);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("dis_dwell_idx", 32'(idx8), 32'd5);
        end
        tick();
        check8("dis_next", 7, 8, 8'h80, 1);

        // Hold with current channel disabled: invalid until released
        hold8 = 1'b1;
        mask8 = 8'h21;
        tick();
        check8("hold_dis", 7, 0, 0, 0);
        hold8 = 1'b0;
        tick();
        check8("hold_dis_rel", 0, 1, 8'h01, 1);

        // Empty mask then a single enabled channel
        mask8 = 8'h00;
        tick();
        check8("empty", 0, 0, 0, 0);
        mask8 = 8'h08;
        tick();
        check8("single", 3, 4, 8'h08, 1);
        for (int n = 0; n < 8; n++) begin
            tick();
            check("single_idx", 32'(idx8), 32'd3);
        end

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check8("async_rst", 0, 0, 0, 0);
        check("async_rst6_idx",   32'(idx6),   32'd0);
        check("async_rst6_valid", 32'(valid6), 32'd0);
        #20;
        check8("rst_held", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check8("post_rst", 3, 4, 8'h08, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_mux.md
# scan_mux

Parametrised, registered N-channel selector for the soda machine datapath and display path. In manual mode it selects one WIDTH-bit channel by index. In scan mode it steps through the enabled channels on its own, staying on each for a programmable number of cycles. It replaces the combinational 8-way selector wherever a registered output, channel masking or time-multiplexed scanning is needed, such as driving a multiplexed seven-segment display.

## Interface
Parameters:
- WIDTH, 4: bits per channel.
- CHANNELS, 8: number of input channels, 2..16.
- SCAN_DIV, 16: cycles spent on each channel in scan mode, ≥1.
- SEL_W (localparam), $clog2(CHANNELS): index width.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- data_in, input, CHANNELS*WIDTH: packed channels; channel k is bits [k*WIDTH +: WIDTH].
- mode, input, 1: 0 = manual, 1 = scan.
- sel, input, SEL_W: channel index in manual mode.
- en_mask, input, CHANNELS: bit k enables channel k in scan mode; ignored in manual mode.
- hold, input, 1: in scan mode, freezes the dwell counter and the channel index.
- y, output, WIDTH: registered selected data.
- ch_idx, output, SEL_W: registered index of the current channel.
- ch_onehot, output, CHANNELS: registered one-hot of ch_idx when valid, otherwise all zero.
- valid, output, 1: registered; high when y carries a legal channel.

## Operation
Reset (rst_n low, asynchronous):
- y=0, ch_idx=0, ch_onehot=0, valid=0, dwell counter=0.
- All outputs stay at these values while rst_n is low.

Manual mode (mode=0):
- Each cycle: ch_idx←sel, counter←0.
- If sel<CHANNELS: y←channel[sel], valid←1, ch_onehot←1<<sel.
- If sel≥CHANNELS: y←0, valid←0, ch_onehot←0.

Scan mode (mode=1):
- cur = current ch_idx. Next-enabled = first k in the circular order cur+1 … cur+CHANNELS (mod CHANNELS) with en_mask[k]=1. If cur is the only enabled channel, next-enabled is cur.
- en_mask=0: y←0, valid←0, ch_onehot←0; ch_idx and counter hold.
- hold=1 with en_mask≠0: ch_idx and counter frozen. y keeps tracking channel[cur], so data changes still propagate.
- Current channel disabled (en_mask[cur]=0, mask≠0, hold=0): jump to next-enabled on the next edge, counter←0. This rule takes priority over the terminal-count rule.
- counter=SCAN_DIV-1: ch_idx←next-enabled, counter←0.
- Otherwise: counter←counter+1.
- Whenever the mask is non-zero: y←channel[new index], valid←1, ch_onehot←1<<new index.
- With hold=1 and the current channel disabled: valid←0 and y←0 until hold is released.

Mode changes:
- Manual→scan: scanning starts from the current ch_idx with counter=0. If ch_idx is out of range or disabled, the disabled-channel jump applies.
- Scan→manual: the next edge follows sel.

Wrap-around: the index goes from CHANNELS-1 to the lowest enabled channel. The counter never exceeds SCAN_DIV-1.

## Timing
- All outputs are registered. Latency from data_in, sel or mode to y/valid is one clock.
- Scan dwell: each enabled channel stays on ch_idx for exactly SCAN_DIV consecutive cycles when hold=0 and the mask is stable.
- Disabled-channel jump takes one cycle. The new channel then gets a full SCAN_DIV dwell.
- hold takes effect on the edge where it is sampled high. Counting resumes from the frozen count on the first edge after it is sampled low.
- rst_n is asserted asynchronously. Deassertion must be synchronous to clk (synchronised upstream). The first active edge after release evaluates normally.

## Test plan
- Reset mid-scan (CHANNELS=8, WIDTH=4): pull rst_n low between edges → y=0, ch_idx=0, valid=0, ch_onehot=0 immediately, with no clock edge needed.
- Manual select: data_in channel k = k+1, mode=0, sel=5 → one cycle later y=6, ch_idx=5, ch_onehot=8'b0010_0000, valid=1. Then sel=7 → y=8.
- Out-of-range select (CHANNELS=6, SEL_W=3): sel=6 → y=0, valid=0, ch_onehot=0.
- Scan with mask (SCAN_DIV=4, en_mask=8'b1010_0101): ch_idx sequence is 0,2,5,7,0, each held exactly 4 cycles. y matches the selected channel throughout.
- Hold and disable: during scan, hold=1 for 10 cycles → ch_idx unchanged and y follows changes on that channel. Release hold, then clear en_mask[cur] → the next edge moves to next-enabled with a full 4-cycle dwell.
- Empty mask: en_mask=0 in scan mode → valid=0, y=0, ch_onehot=0, ch_idx held. Then restore en_mask=8'b0000_1000 → ch_idx=3 on the next edge and stays there (single enabled channel).
